// File: rtl/fmdll_pkg.sv
// fmdll_pkg
// Shared definitions for the FMDLL divider / select logic.
//   MW_DEF, NW_DEF : default widths of the M and N settings
//   M_MIN, N_MIN   : smallest legal frame length and DIV_N period
//   clamp_m/clamp_n: map a requested setting onto its legal range
//   cfg_state_t    : state of the configuration handshake
package fmdll_pkg;

  localparam int MW_DEF = 2;
  localparam int NW_DEF = 4;

  localparam int unsigned M_MIN = 1;
  localparam int unsigned N_MIN = 2;

  typedef enum logic {
    CFG_IDLE,
    CFG_PENDING
  } cfg_state_t;

  // A zero-length frame is meaningless, so it becomes a one-cycle frame.
  function automatic int unsigned clamp_m(input int unsigned m);
    return (m < M_MIN) ? M_MIN : m;
  endfunction

  // DIV_N needs at least one high and one low cycle.
  function automatic int unsigned clamp_n(input int unsigned n);
    return (n < N_MIN) ? N_MIN : n;
  endfunction

endpackage

// File: rtl/mod_down_counter.sv
// mod_down_counter
// Down counter that runs load_val..1 and reloads after reaching 1.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, loads rst_val
//   en       : count enable; 0 holds the count
//   rst_val  : value loaded on reset
//   load_val : value loaded on the enabled cycle where the count is 1
//   count    : current count
//   tc       : terminal count, high while count == 1
module mod_down_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] rst_val,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         tc
);

  assign tc = (count == W'(1));

  // The count never passes through zero: at 1 it reloads instead of
  // decrementing, so a load value of 1 simply holds at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= rst_val;
    end else if (en) begin
      if (tc) begin
        count <= load_val;
      end else begin
        count <= count - W'(1);
      end
    end
  end

endmodule

// File: rtl/fmdll_div_gen.sv
// fmdll_div_gen
// Divider / phase-counter stage feeding the FMDLL select logic.
//   clk_out   : DLL output clock, the only clock
//   rst       : synchronous active-high reset
//   en        : count enable; 0 freezes counters and masks DIV_M
//   M_in      : requested frame length (cycles)
//   N_in      : requested DIV_N period (cycles)
//   cfg_upd   : one-cycle request to adopt M_in / N_in
//   cfg_ack   : one-cycle pulse when the new settings take effect
//   M         : active (clamped) frame length
//   M_counter : position within the frame, counts M..1
//   DIV_M     : frame pulse, high when M_counter is 1 and en is high
//   DIV_N     : divide-by-N wave, high for ceil(N/2) cycles
module fmdll_div_gen
  import fmdll_pkg::*;
#(
  parameter int NW = NW_DEF,
  parameter int MW = MW_DEF
) (
  input  logic          clk_out,
  input  logic          rst,
  input  logic          en,
  input  logic [MW-1:0] M_in,
  input  logic [NW-1:0] N_in,
  input  logic          cfg_upd,
  output logic          cfg_ack,
  output logic [MW-1:0] M,
  output logic [MW-1:0] M_counter,
  output logic          DIV_M,
  output logic          DIV_N
);

  logic [MW-1:0] m_in_eff;
  logic [NW-1:0] n_in_eff;
  logic [MW-1:0] m_act;
  logic [NW-1:0] n_act;
  logic [MW-1:0] m_shadow;
  logic [NW-1:0] n_shadow;
  logic [MW-1:0] m_reload;
  logic [NW-1:0] n_cnt;
  logic [NW-1:0] n_cnt_inc;
  logic [NW:0]   n_high;
  logic          m_tc;
  logic          apply;
  cfg_state_t    cfg_state;
  cfg_state_t    cfg_state_next;

  assign m_in_eff = MW'(clamp_m(32'(M_in)));
  assign n_in_eff = NW'(clamp_n(32'(N_in)));

  // New settings only land on a frame boundary so the select logic never
  // sees a truncated frame.
  assign apply    = en && m_tc && (cfg_state == CFG_PENDING);
  assign m_reload = apply ? m_shadow : m_act;

  // Frame position counter; reloads from the shadow M when a pending
  // configuration is applied at the boundary.
  mod_down_counter #(
    .W(MW)
  ) u_m_counter (
    .clk      (clk_out),
    .rst      (rst),
    .en       (en),
    .rst_val  (m_in_eff),
    .load_val (m_reload),
    .count    (M_counter),
    .tc       (m_tc)
  );

  // Handshake state: a capture always wins over a simultaneous apply, so a
  // request arriving on the boundary stays pending for the next frame.
  always_comb begin
    cfg_state_next = cfg_state;
    if (cfg_upd) begin
      cfg_state_next = CFG_PENDING;
    end else if (apply) begin
      cfg_state_next = CFG_IDLE;
    end
  end

  // Handshake state register.
  always_ff @(posedge clk_out) begin
    if (rst) begin
      cfg_state <= CFG_IDLE;
    end else begin
      cfg_state <= cfg_state_next;
    end
  end

  // Shadow settings: captured (already clamped) on every request, even
  // while en is low; the last request before the boundary wins.
  always_ff @(posedge clk_out) begin
    if (rst) begin
      m_shadow <= m_in_eff;
      n_shadow <= n_in_eff;
    end else if (cfg_upd) begin
      m_shadow <= m_in_eff;
      n_shadow <= n_in_eff;
    end
  end

  // Active settings: loaded straight from the inputs at reset, otherwise
  // only from the shadow at an applying boundary.
  always_ff @(posedge clk_out) begin
    if (rst) begin
      m_act <= m_in_eff;
      n_act <= n_in_eff;
    end else if (apply) begin
      m_act <= m_shadow;
      n_act <= n_shadow;
    end
  end

  // Next N phase and the length of the high part of DIV_N. ceil(N/2) is
  // formed one bit wider so N at full scale does not overflow.
  always_comb begin
    n_cnt_inc = (n_cnt == n_act - NW'(1)) ? '0 : n_cnt + NW'(1);
    n_high    = ({1'b0, n_act} + {{NW{1'b0}}, 1'b1}) >> 1;
  end

  // N phase counter and registered DIV_N; DIV_N always reflects the phase
  // held in n_cnt, and both restart together when new settings apply.
  always_ff @(posedge clk_out) begin
    if (rst) begin
      n_cnt <= '0;
      DIV_N <= 1'b1;
    end else if (en) begin
      if (apply) begin
        n_cnt <= '0;
        DIV_N <= 1'b1;
      end else begin
        n_cnt <= n_cnt_inc;
        DIV_N <= ({1'b0, n_cnt_inc} < n_high);
      end
    end
  end

  // Acknowledge appears together with the new M on the output.
  always_ff @(posedge clk_out) begin
    if (rst) begin
      cfg_ack <= 1'b0;
    end else begin
      cfg_ack <= apply;
    end
  end

  assign M     = m_act;
  assign DIV_M = en && m_tc;

endmodule

// File: tb/tb_fmdll_div_gen.sv
// tb_fmdll_div_gen
// Self-checking bench for fmdll_div_gen: a table of hand-derived vectors,
// a few directed multi-cycle sequences, and randomized traffic checked
// against a frame/phase model of the divider.
module tb_fmdll_div_gen;

  localparam int MW = 2;
  localparam int NW = 4;

  logic          clk_out = 1'b0;
  logic          rst;
  logic          en;
  logic [MW-1:0] M_in;
  logic [NW-1:0] N_in;
  logic          cfg_upd;
  logic          cfg_ack;
  logic [MW-1:0] M;
  logic [MW-1:0] M_counter;
  logic          DIV_M;
  logic          DIV_N;

  int testsRun    = 0;
  int testsFailed = 0;
  int ackSeen     = 0;

  // Model state: frame length and index inside the frame, N period and
  // phase, pending request with its settings, and the expected ack.
  bit modelValid = 1'b0;
  int mAct, nAct, mPos, nPos, shM, shN;
  bit pend, ackExp;

  typedef struct {
    logic r, e, u;
    int   mi, ni;
    bit   chk;
    int   eM, eMc, eDivM, eDivN, eAck;
  } vec_t;

  vec_t vecs[$];

  fmdll_div_gen #(
    .NW(NW),
    .MW(MW)
  ) dut (
    .clk_out   (clk_out),
    .rst       (rst),
    .en        (en),
    .M_in      (M_in),
    .N_in      (N_in),
    .cfg_upd   (cfg_upd),
    .cfg_ack   (cfg_ack),
    .M         (M),
    .M_counter (M_counter),
    .DIV_M     (DIV_M),
    .DIV_N     (DIV_N)
  );

  always #5 clk_out = ~clk_out;

  task automatic addVec(input logic r, e, u, input int mi, ni, input bit chk,
                        input int eM, eMc, eDivM, eDivN, eAck);
    vec_t v;
    v.r = r; v.e = e; v.u = u; v.mi = mi; v.ni = ni; v.chk = chk;
    v.eM = eM; v.eMc = eMc; v.eDivM = eDivM; v.eDivN = eDivN; v.eAck = eAck;
    vecs.push_back(v);
  endtask

  task automatic checkVal(input string name, input logic [31:0] act,
                          input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput(input int eM, eMc, eDivM, eDivN, eAck);
    checkVal("M", 32'(M), eM);
    checkVal("M_counter", 32'(M_counter), eMc);
    checkVal("DIV_M", 32'(DIV_M), eDivM);
    checkVal("DIV_N", 32'(DIV_N), eDivN);
    checkVal("cfg_ack", 32'(cfg_ack), eAck);
  endtask

  task automatic applyStimulus(input logic r, e, u, input int mi, ni);
    rst     = r;
    en      = e;
    cfg_upd = u;
    M_in    = MW'(mi);
    N_in    = NW'(ni);
  endtask

  function automatic int clampM(input int m);
    return (m == 0) ? 1 : m;
  endfunction

  function automatic int clampN(input int n);
    return (n < 2) ? 2 : n;
  endfunction

  // Model step for one rising edge, using the inputs held across it.
  task automatic modelAdvance();
    bit applyNow;
    if (rst) begin
      mAct = clampM(int'(M_in));
      nAct = clampN(int'(N_in));
      shM = mAct; shN = nAct;
      mPos = 0; nPos = 0;
      pend = 1'b0; ackExp = 1'b0;
      modelValid = 1'b1;
    end else begin
      applyNow = en && (mPos == mAct - 1) && pend;
      ackExp = applyNow;
      if (en) begin
        if (applyNow) begin
          mAct = shM; nAct = shN;
          mPos = 0; nPos = 0;
        end else begin
          mPos = (mPos + 1) % mAct;
          nPos = (nPos + 1) % nAct;
        end
      end
      if (cfg_upd) begin
        shM = clampM(int'(M_in));
        shN = clampN(int'(N_in));
        pend = 1'b1;
      end else if (applyNow) begin
        pend = 1'b0;
      end
    end
  endtask

  task automatic checkModel();
    if (modelValid) begin
      checkOutput(mAct, mAct - mPos, (en && (mAct - mPos == 1)) ? 1 : 0,
                  (nPos < (nAct + 1) / 2) ? 1 : 0, ackExp ? 1 : 0);
    end
  endtask

  task automatic tick();
    @(posedge clk_out);
    modelAdvance();
    #1;
  endtask

  task automatic runCycle(input logic r, e, u, input int mi, ni);
    applyStimulus(r, e, u, mi, ni);
    #1;
    checkModel();
    if (cfg_ack === 1'b1) ackSeen++;
    tick();
  endtask

  initial begin
    // Reset with M=3, N=4, request M=2/N=6 at M_counter=3, then drop en
    // for four cycles at M_counter=2.
    addVec(1, 1, 0, 3, 4, 0, 0, 0, 0, 0, 0);
    addVec(0, 1, 0, 3, 4, 1, 3, 3, 0, 1, 0);
    addVec(0, 1, 0, 3, 4, 1, 3, 2, 0, 1, 0);
    addVec(0, 1, 0, 3, 4, 1, 3, 1, 1, 0, 0);
    addVec(0, 1, 0, 3, 4, 1, 3, 3, 0, 0, 0);
    addVec(0, 1, 0, 3, 4, 1, 3, 2, 0, 1, 0);
    addVec(0, 1, 0, 3, 4, 1, 3, 1, 1, 1, 0);
    addVec(0, 1, 1, 2, 6, 1, 3, 3, 0, 0, 0);
    addVec(0, 1, 0, 2, 6, 1, 3, 2, 0, 0, 0);
    addVec(0, 1, 0, 2, 6, 1, 3, 1, 1, 1, 0);
    addVec(0, 1, 0, 2, 6, 1, 2, 2, 0, 1, 1);
    addVec(0, 1, 0, 2, 6, 1, 2, 1, 1, 1, 0);
    addVec(0, 1, 0, 2, 6, 1, 2, 2, 0, 1, 0);
    addVec(0, 1, 0, 2, 6, 1, 2, 1, 1, 0, 0);
    addVec(0, 1, 0, 2, 6, 1, 2, 2, 0, 0, 0);
    addVec(0, 1, 0, 2, 6, 1, 2, 1, 1, 0, 0);
    addVec(0, 0, 0, 2, 6, 1, 2, 2, 0, 1, 0);
    addVec(0, 0, 0, 2, 6, 1, 2, 2, 0, 1, 0);
    addVec(0, 0, 0, 2, 6, 1, 2, 2, 0, 1, 0);
    addVec(0, 0, 0, 2, 6, 1, 2, 2, 0, 1, 0);
    addVec(0, 1, 0, 2, 6, 1, 2, 2, 0, 1, 0);
    addVec(0, 1, 0, 2, 6, 1, 2, 1, 1, 1, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].r, vecs[i].e, vecs[i].u, vecs[i].mi, vecs[i].ni);
      #1;
      if (vecs[i].chk) begin
        checkOutput(vecs[i].eM, vecs[i].eMc, vecs[i].eDivM, vecs[i].eDivN, vecs[i].eAck);
      end
      tick();
    end

    // Clamped settings at reset: M=1, N=2.
    runCycle(1, 1, 0, 0, 1);
    for (int i = 0; i < 6; i++) runCycle(0, 1, 0, 0, 1);
    checkVal("clamp_M", 32'(M), 1);

    // Two requests within one frame: only the last one applies, one ack.
    runCycle(1, 1, 0, 3, 4);
    ackSeen = 0;
    runCycle(0, 1, 1, 2, 4);
    runCycle(0, 1, 1, 1, 5);
    for (int i = 0; i < 6; i++) runCycle(0, 1, 0, 1, 5);
    checkVal("dbl_upd_acks", ackSeen, 1);
    checkVal("dbl_upd_M", 32'(M), 1);

    // Reset while a request is pending discards it.
    runCycle(1, 1, 0, 3, 4);
    runCycle(0, 1, 1, 1, 7);
    runCycle(1, 1, 0, 2, 3);
    ackSeen = 0;
    for (int i = 0; i < 6; i++) runCycle(0, 1, 0, 2, 3);
    checkVal("rst_pend_acks", ackSeen, 0);
    checkVal("rst_pend_M", 32'(M), 2);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      runCycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0),
               ($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fmdll_div_gen.md
# fmdll_div_gen

Programmable divider and phase-counter stage upstream of the FMDLL select logic. It counts `clk_out` cycles and produces `DIV_M` (one-cycle frame pulse every M cycles), `DIV_N` (divide-by-N clock enable/wave) and `M_counter` (position within the M frame), which the select logic consumes to choose its mux input. New M/N settings are taken through a pulse/acknowledge handshake and applied only on an M-frame boundary, so the select logic never sees a truncated frame.

## Interface
- `NW`, default 4: width of N setting and N counter.
- `MW`, default 2: width of M setting and `M_counter` (matches 2-bit `M` on select logic).
- `clk_out` in 1: sole clock (DLL output clock); all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `en` in 1: count enable; 0 freezes all counters.
- `M_in` in MW: requested M (frame length in cycles).
- `N_in` in NW: requested N (DIV_N period in cycles).
- `cfg_upd` in 1: one-cycle request to adopt `M_in`/`N_in`.
- `cfg_ack` out 1: one-cycle pulse, cycle the new config takes effect.
- `M` out MW: active (clamped) M, fed to select logic.
- `M_counter` out MW: frame position, counts down M..1.
- `DIV_M` out 1: high in the cycle where `M_counter`==1 and `en`=1.
- `DIV_N` out 1: divide-by-N wave.

## Operation
- Clamping: M_eff = (M_in==0) ? 1 : M_in; N_eff = (N_in<2) ? 2 : N_in. Clamp applied on capture; active registers always hold legal values.
- Reset: active M/N loaded from clamped `M_in`/`N_in`; `M_counter`=M_eff; n_cnt=0; `DIV_N`=1; `cfg_ack`=0; pending flag=0. `DIV_M`=1 after reset only if M_eff==1 and `en`=1.
- M counter: each enabled cycle, if `M_counter`==1 reload to active M, else decrement.
- N counter: n_cnt counts 0..N-1, wraps to 0. `DIV_N` = (n_cnt < ceil(N/2)), registered: high ceil(N/2) cycles, low floor(N/2) cycles.
- Config handshake: `cfg_upd` captures clamped `M_in`/`N_in` into shadow registers, sets pending. Repeat `cfg_upd` while pending overwrites shadow (last wins), no extra ack.
- Apply: on the enabled cycle where `M_counter`==1 and pending=1: active M/N ← shadow; `M_counter` ← new M; n_cnt ← 0; `DIV_N` ← 1; pending cleared; `cfg_ack`=1 the following cycle (same cycle the new M appears on `M`).
- `cfg_upd` in same cycle as apply: the apply uses old shadow; new capture stays pending for next boundary.
- `en`=0: counters, `DIV_N`, pending and shadow-apply frozen; `DIV_M` forced 0; `cfg_upd` still captured.
- `rst` mid-frame or with pending: pending discarded, no `cfg_ack`, reset values as above.

## Timing
- All outputs registered except `DIV_M`, a decode of `M_counter` and `en`; no combinational path from `M_in`/`N_in` to any output.
- M=3: `M_counter` 3,2,1,3,2,1…; `DIV_M` 0,0,1,0,0,1.
- M=1: `M_counter` stays 1; `DIV_M` high every enabled cycle.
- N=5: n_cnt 0,1,2,3,4,0; `DIV_N` 1,1,1,0,0,1.
- Apply latency: `cfg_upd` at cycle t, boundary at cycle b ≥ t+1 → new `M`/`M_counter` and `cfg_ack` at b+1. Worst case M_old cycles plus 1.

## Structure
- Package `fmdll_pkg`: `MW`/`NW` defaults, `clamp_m`/`clamp_n` functions, M_MIN=1, N_MIN=2 constants; shared with select logic.
- One sub-module `mod_down_counter` (width param, load value, enable, terminal-count flag) used for M counter; N counter inline.

## Test plan
- Reset with M_in=3, N_in=4, en=1 → `M_counter` 3,2,1,3; `DIV_M` pulses every 3rd cycle; `DIV_N` 1,1,0,0 repeating.
- M_in=0, N_in=1 at reset → `M`=1, `DIV_M` constant 1, `DIV_N` toggles every cycle (N=2).
- At `M_counter`=3 (M=3), pulse `cfg_upd` with M_in=2, N_in=6 → applied 3 cycles later; `cfg_ack` one cycle; then `M_counter` 2,1,2,1, `DIV_N` 1,1,1,0,0,0.
- Two `cfg_upd` pulses (M_in=2 then M_in=1) within one frame → single `cfg_ack`, active M=1.
- Drop `en` for 4 cycles at `M_counter`=2 → outputs hold, `DIV_M`=0; resume at `M_counter`=2 with no lost count.
- Assert `rst` while pending → no `cfg_ack`; state equals reset values from current `M_in`/`N_in`.
